// File: rtl/fir_bridge_pkg.sv
// Shared constants and state encoding for the Wishbone-to-FIR bridge.
package fir_bridge_pkg;

   // Register offsets within the 256-byte bridge window
   localparam logic [7:0] OFF_AP_CTRL = 8'h00;
   localparam logic [7:0] OFF_DLEN    = 8'h10;
   localparam logic [7:0] OFF_TAP_LO  = 8'h40;
   localparam logic [7:0] OFF_TAP_HI  = 8'h7F;
   localparam logic [7:0] OFF_X       = 8'h80;
   localparam logic [7:0] OFF_Y       = 8'h84;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LITE_WR,
      ST_LITE_RD,
      ST_SS_PUSH,
      ST_SM_POP,
      ST_ACK
   } state_t;

   // Offsets 0x00-0x7F are forwarded to the FIR AXI-Lite register file
   function automatic logic is_lite(input logic [7:0] offset);
      return (offset[7] == 1'b0);
   endfunction

endpackage

// File: rtl/axil_master_if.sv
// AXI-Lite master channel bookkeeping: one write (aw+w) or one read (ar then r)
// per start pulse, with done reported combinationally on the completing edge.
module axil_master_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_wr,
   input  logic              start_rd,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata_in,
   output logic [ADDR_W-1:0] awaddr,
   output logic              awvalid,
   input  logic              awready,
   output logic [DATA_W-1:0] wdata,
   output logic              wvalid,
   input  logic              wready,
   output logic [ADDR_W-1:0] araddr,
   output logic              arvalid,
   input  logic              arready,
   input  logic              rvalid,
   output logic              rready,
   input  logic [DATA_W-1:0] rdata,
   output logic              wr_done,
   output logic              rd_done,
   output logic [DATA_W-1:0] rd_data
);

   logic aw_ok, w_ok;
   logic aw_hs, w_hs;

   assign aw_hs   = awvalid & awready;
   assign w_hs    = wvalid & wready;
   // Either channel may finish first or both together; done when both have
   assign wr_done = (aw_ok | aw_hs) & (w_ok | w_hs);
   assign rd_done = rready & rvalid;
   assign rd_data = rdata;

   // Write channels: raise together, drop each on its own handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         awvalid <= 1'b0;
         wvalid  <= 1'b0;
         aw_ok   <= 1'b0;
         w_ok    <= 1'b0;
         awaddr  <= '0;
         wdata   <= '0;
      end else if (start_wr) begin
         awvalid <= 1'b1;
         wvalid  <= 1'b1;
         aw_ok   <= 1'b0;
         w_ok    <= 1'b0;
         awaddr  <= addr;
         wdata   <= wdata_in;
      end else begin
         if (aw_hs) begin
            awvalid <= 1'b0;
            aw_ok   <= 1'b1;
         end
         if (w_hs) begin
            wvalid <= 1'b0;
            w_ok   <= 1'b1;
         end
         if (wr_done) begin
            aw_ok <= 1'b0;
            w_ok  <= 1'b0;
         end
      end
   end

   // Read channels: address phase first, then accept exactly one data beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arvalid <= 1'b0;
         rready  <= 1'b0;
         araddr  <= '0;
      end else if (start_rd) begin
         arvalid <= 1'b1;
         araddr  <= addr;
      end else if (arvalid && arready) begin
         arvalid <= 1'b0;
         rready  <= 1'b1;
      end else if (rd_done) begin
         rready <= 1'b0;
      end
   end

endmodule

// File: rtl/wb_fir_bridge.sv
// Wishbone slave that turns each CPU access into one FIR handshake (AXI-Lite,
// X stream push or Y stream pop) and stretches the cycle until it completes.
module wb_fir_bridge
   import fir_bridge_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          ADDR_W    = 12,
   parameter int          DATA_W    = 32
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   output logic [ADDR_W-1:0] awaddr,
   output logic              awvalid,
   input  logic              awready,
   output logic [DATA_W-1:0] wdata,
   output logic              wvalid,
   input  logic              wready,
   output logic [ADDR_W-1:0] araddr,
   output logic              arvalid,
   input  logic              arready,
   input  logic              rvalid,
   output logic              rready,
   input  logic [DATA_W-1:0] rdata,
   output logic [DATA_W-1:0] ss_tdata,
   output logic              ss_tvalid,
   output logic              ss_tlast,
   input  logic              ss_tready,
   input  logic [DATA_W-1:0] sm_tdata,
   input  logic              sm_tvalid,
   input  logic              sm_tlast,
   output logic              sm_tready
);

   state_t      state, state_n;
   logic [7:0]  offset, off_q;
   logic [31:0] dat_q;
   logic [31:0] len_shadow;
   logic [31:0] x_cnt;
   logic        hit, req;
   logic        start_wr, start_rd;
   logic        wr_done, rd_done;
   logic [DATA_W-1:0] rd_data;
   logic        unused_ok;

   // Byte enables are irrelevant (full-word only) and Y framing is not used
   assign unused_ok = ^{wbs_sel_i, sm_tlast};

   assign offset = wbs_adr_i[7:0];
   assign hit    = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign req    = wbs_cyc_i & wbs_stb_i & hit;

   assign wbs_ack_o = (state == ST_ACK);
   assign ss_tvalid = (state == ST_SS_PUSH);
   assign ss_tdata  = dat_q;
   assign ss_tlast  = ss_tvalid && (len_shadow != 32'd0) &&
                      (x_cnt == len_shadow - 32'd1);
   assign sm_tready = (state == ST_SM_POP);

   axil_master_if #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_axil (
      .clk      (wb_clk_i),
      .rst_n    (wb_rst_i),
      .start_wr (start_wr),
      .start_rd (start_rd),
      .addr     (wbs_adr_i[ADDR_W-1:0]),
      .wdata_in (wbs_dat_i),
      .awaddr   (awaddr),
      .awvalid  (awvalid),
      .awready  (awready),
      .wdata    (wdata),
      .wvalid   (wvalid),
      .wready   (wready),
      .araddr   (araddr),
      .arvalid  (arvalid),
      .arready  (arready),
      .rvalid   (rvalid),
      .rready   (rready),
      .rdata    (rdata),
      .wr_done  (wr_done),
      .rd_done  (rd_done),
      .rd_data  (rd_data)
   );

   // State register
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) state <= ST_IDLE;
      else           state <= state_n;
   end

   // Next state and AXI-Lite start pulses; a request is decoded once in IDLE
   always_comb begin
      state_n  = state;
      start_wr = 1'b0;
      start_rd = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req) begin
               if (is_lite(offset)) begin
                  if (wbs_we_i) begin
                     start_wr = 1'b1;
                     state_n  = ST_LITE_WR;
                  end else begin
                     start_rd = 1'b1;
                     state_n  = ST_LITE_RD;
                  end
               end else if (offset == OFF_X && wbs_we_i) begin
                  state_n = ST_SS_PUSH;
               end else if (offset == OFF_Y && !wbs_we_i) begin
                  state_n = ST_SM_POP;
               end else begin
                  state_n = ST_ACK;
               end
            end
         end
         ST_LITE_WR: if (wr_done)   state_n = ST_ACK;
         ST_LITE_RD: if (rd_done)   state_n = ST_ACK;
         ST_SS_PUSH: if (ss_tready) state_n = ST_ACK;
         ST_SM_POP:  if (sm_tvalid) state_n = ST_ACK;
         ST_ACK:                    state_n = ST_IDLE;
         default:                   state_n = ST_IDLE;
      endcase
   end

   // Request latch, read-data capture, length shadow and X sample counter
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         off_q      <= '0;
         dat_q      <= '0;
         wbs_dat_o  <= '0;
         len_shadow <= '0;
         x_cnt      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req) begin
                  off_q <= offset;
                  dat_q <= wbs_dat_i;
                  // Unmapped reads (including a read of the X port) return 0
                  if (state_n == ST_ACK && !wbs_we_i) wbs_dat_o <= '0;
               end
            end
            ST_LITE_WR: begin
               if (wr_done) begin
                  if (off_q == OFF_DLEN) len_shadow <= dat_q;
                  if (off_q == OFF_AP_CTRL && dat_q[0]) x_cnt <= '0;
               end
            end
            ST_LITE_RD: begin
               if (rd_done) wbs_dat_o <= rd_data;
            end
            ST_SS_PUSH: begin
               if (ss_tready) x_cnt <= ss_tlast ? 32'd0 : x_cnt + 32'd1;
            end
            ST_SM_POP: begin
               if (sm_tvalid) wbs_dat_o <= sm_tdata;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_fir_bridge.sv
// Self-checking bench for wb_fir_bridge: directed scenarios then random
// accesses, compared against a transaction-level model of the bridge.
module tb_wb_fir_bridge;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'hF;
   logic [31:0] adr = '0, dat = '0;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic [11:0] awaddr, araddr;
   logic        awvalid, wvalid, arvalid, rready;
   logic        awready = 1'b0, wready = 1'b0, arready = 1'b0, rvalid = 1'b0;
   logic [31:0] wdata, rdata = '0;
   logic [31:0] ss_tdata;
   logic        ss_tvalid, ss_tlast;
   logic        ss_tready = 1'b0;
   logic [31:0] sm_tdata = '0;
   logic        sm_tvalid = 1'b0, sm_tlast = 1'b0;
   logic        sm_tready;

   always #5 clk = ~clk;

   wb_fir_bridge dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst_n),
      .wbs_cyc_i (cyc),
      .wbs_stb_i (stb),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_adr_i (adr),
      .wbs_dat_i (dat),
      .wbs_ack_o (wbs_ack_o),
      .wbs_dat_o (wbs_dat_o),
      .awaddr    (awaddr),
      .awvalid   (awvalid),
      .awready   (awready),
      .wdata     (wdata),
      .wvalid    (wvalid),
      .wready    (wready),
      .araddr    (araddr),
      .arvalid   (arvalid),
      .arready   (arready),
      .rvalid    (rvalid),
      .rready    (rready),
      .rdata     (rdata),
      .ss_tdata  (ss_tdata),
      .ss_tvalid (ss_tvalid),
      .ss_tlast  (ss_tlast),
      .ss_tready (ss_tready),
      .sm_tdata  (sm_tdata),
      .sm_tvalid (sm_tvalid),
      .sm_tlast  (sm_tlast),
      .sm_tready (sm_tready)
   );

   int checks = 0, passes = 0, fails = 0;

   // observations from the last access
   int          obs_lat, obs_acks, obs_awlast, obs_wlast;
   logic [31:0] obs_dat, obs_axaddr, obs_wdata;
   logic        obs_rr_early, obs_ss_bad, obs_tlast;

   // reference model state
   logic [31:0] m_len = '0, m_xcnt = '0, m_last = '0;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic drop_drives();
      cyc = 0; stb = 0;
      awready = 0; wready = 0; arready = 0; rvalid = 0;
      ss_tready = 0; sm_tvalid = 0;
   endtask

   // One Wishbone access acting as every FIR-side responder. d1/d2 are the
   // ready/valid delays (aw/w, ar/r, ss, sm), counted in cycles of valid seen.
   task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input int d1, input int d2, input logic [31:0] resp,
                         input int budget);
      int aw_n = 0, w_n = 0, ar_n = 0, r_n = 0, ss_n = 0, sm_n = 0;
      logic ar_hs = 0;
      bit done = 0;
      obs_lat = -1; obs_acks = 0; obs_awlast = -1; obs_wlast = -1;
      obs_dat = 'x; obs_axaddr = 'x; obs_wdata = 'x;
      obs_rr_early = 0; obs_ss_bad = 0; obs_tlast = 0;
      @(negedge clk);
      cyc = 1; stb = 1; we = w; adr = a; dat = d;
      for (int k = 1; k <= budget && !done; k++) begin
         @(negedge clk);
         if (wbs_ack_o) begin
            obs_acks++; obs_lat = k + 1; obs_dat = wbs_dat_o; done = 1;
            drop_drives();
         end else begin
            if (rready && !ar_hs) obs_rr_early = 1;
            if (awvalid) begin
               obs_awlast = k; obs_axaddr = {20'd0, awaddr}; obs_wdata = wdata;
               awready = (aw_n >= d1); aw_n++;
            end else awready = 0;
            if (wvalid) begin
               obs_wlast = k; obs_wdata = wdata;
               wready = (w_n >= d2); w_n++;
            end else wready = 0;
            if (arvalid) begin
               obs_axaddr = {20'd0, araddr};
               arready = (ar_n >= d1); ar_n++;
            end else arready = 0;
            if (ar_hs) begin
               rvalid = (r_n >= d2); rdata = resp; r_n++;
            end
            if (ss_tvalid) begin
               if (ss_n == 0) obs_tlast = ss_tlast;
               else if (ss_tlast !== obs_tlast) obs_ss_bad = 1;
               if (ss_tdata !== d) obs_ss_bad = 1;
               ss_tready = (ss_n >= d1); ss_n++;
            end else ss_tready = 0;
            if (sm_tready) begin
               sm_tvalid = (sm_n >= d1); sm_tdata = resp; sm_n++;
            end else sm_tvalid = 0;
            if (arvalid && arready) ar_hs = 1;
         end
      end
      drop_drives();
      repeat (3) begin
         @(negedge clk);
         if (wbs_ack_o) obs_acks++;
      end
   endtask

   // Access plus expectations derived from the address map and handshake rules
   task automatic run(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input int d1, input int d2,
                      input logic [31:0] resp);
      logic [7:0]  off;
      logic        lite, push, pop;
      int          e_lat;
      logic [31:0] e_dat;
      logic        e_tlast;
      off  = a[7:0];
      lite = (off < 8'h80);
      push = (off == 8'h80) && w;
      pop  = (off == 8'h84) && !w;
      if (lite && w)      e_lat = 3 + ((d1 > d2) ? d1 : d2);
      else if (lite)      e_lat = 4 + d1 + d2;
      else if (push||pop) e_lat = 3 + d1;
      else                e_lat = 2;
      if (w)                e_dat = m_last;
      else if (lite || pop) e_dat = resp;
      else                  e_dat = 32'd0;
      e_tlast = (m_len != 0) && (m_xcnt == m_len - 1);

      access(w, a, d, d1, d2, resp, 40);
      chk({tag, "_acks"}, obs_acks, 1);
      chk({tag, "_lat"}, obs_lat, e_lat);
      chk({tag, "_dat"}, obs_dat, e_dat);
      if (lite) chk({tag, "_axaddr"}, obs_axaddr, {20'd0, a[11:0]});
      if (lite && w) begin
         chk({tag, "_awlast"}, obs_awlast, 1 + d1);
         chk({tag, "_wlast"}, obs_wlast, 1 + d2);
         chk({tag, "_wdata"}, obs_wdata, d);
      end
      if (lite && !w) chk({tag, "_rready_early"}, obs_rr_early, 0);
      if (push) begin
         chk({tag, "_tlast"}, obs_tlast, e_tlast);
         chk({tag, "_ss_stable"}, obs_ss_bad, 0);
      end

      m_last = e_dat;
      if (lite && w && off == 8'h10) m_len = d;
      if (lite && w && off == 8'h00 && d[0]) m_xcnt = 0;
      if (push) m_xcnt = e_tlast ? 32'd0 : m_xcnt + 1;
   endtask

   initial begin
      logic [7:0] offs [10];
      offs = '{8'h00, 8'h10, 8'h40, 8'h5C, 8'h7C, 8'h80, 8'h84, 8'h20, 8'h88, 8'hFC};

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_ack", wbs_ack_o, 0);
      chk("rst_dat", wbs_dat_o, 0);
      chk("rst_valids", {awvalid, wvalid, arvalid, rready, ss_tvalid, sm_tready}, 0);
      chk("rst_addr", {awaddr, araddr}, 0);
      rst_n = 1;

      // data_length=64, awready delayed 2, wready immediate
      run("dlen64", 1, 32'h3000_0010, 32'd64, 2, 0, 0);
      // tap read, arready immediate, rvalid after 3 cycles
      run("tapread", 0, 32'h3000_0040, 0, 0, 3, 32'h0000_1234);
      // tlast generation over a 3-sample frame
      run("dlen3", 1, 32'h3000_0010, 32'd3, 0, 0, 0);
      run("apstart", 1, 32'h3000_0000, 32'd1, 1, 1, 0);
      run("x0", 1, 32'h3000_0080, 32'h11, 0, 0, 0);
      run("x1", 1, 32'h3000_0080, 32'h22, 0, 0, 0);
      run("x2", 1, 32'h3000_0080, 32'h33, 0, 0, 0);
      run("x3", 1, 32'h3000_0080, 32'h44, 0, 0, 0);
      // backpressure on X stream
      run("xstall", 1, 32'h3000_0080, 32'hDEAD_BEEF, 10, 0, 0);
      // Y pop and ack-only read of the X port
      run("ypop", 0, 32'h3000_0084, 0, 0, 0, 32'hFFFF_FFF0);
      run("xread", 0, 32'h3000_0080, 0, 0, 0, 0);
      run("ywrite", 1, 32'h3000_0084, 32'h5, 0, 0, 0);

      // non-hit address is never acked
      access(0, 32'h3000_0100, 0, 0, 0, 0, 10);
      chk("nohit_acks", obs_acks, 0);

      // reset in the middle of a LITE write
      @(negedge clk);
      cyc = 1; stb = 1; we = 1; adr = 32'h3000_0010; dat = 32'd7;
      repeat (2) @(negedge clk);
      chk("midrst_pre_awvalid", awvalid, 1);
      rst_n = 0; cyc = 0; stb = 0;
      #1;
      chk("midrst_aw_w", {awvalid, wvalid}, 0);
      chk("midrst_ack", wbs_ack_o, 0);
      @(negedge clk);
      rst_n = 1;
      obs_acks = 0;
      repeat (5) begin
         @(negedge clk);
         if (wbs_ack_o) obs_acks++;
      end
      chk("midrst_noack", obs_acks, 0);
      chk("midrst_idle_valids", {awvalid, wvalid, arvalid, rready, ss_tvalid, sm_tready}, 0);
      chk("midrst_dat", wbs_dat_o, 0);
      m_len = 0; m_xcnt = 0; m_last = 0;
      run("postrst_x", 1, 32'h3000_0080, 32'h99, 0, 0, 0);

      // randomized accesses
      for (int i = 0; i < 60; i++) begin
         logic [7:0]  off;
         logic        w;
         logic [31:0] d;
         off = offs[$urandom_range(0, 9)];
         w = $urandom_range(0, 1);
         d = $urandom;
         if (off == 8'h10) d = $urandom_range(0, 5);
         run("rnd", w, 32'h3000_0000 | {24'd0, off}, d,
             $urandom_range(0, 4), $urandom_range(0, 4), $urandom);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/wb_fir_bridge.md
Name: wb_fir_bridge

Overview:
- Wishbone slave inside the user project area. It translates management-SoC Wishbone accesses into transactions on the FIR engine's interfaces:
  - AXI-Lite master for configuration and taps.
  - AXI-Stream master for X samples.
  - AXI-Stream slave for Y results.
- It sequences each CPU access into exactly one FIR handshake, holds the Wishbone master with wait states until that handshake completes, and generates X-stream tlast from a shadowed data_length.

Parameters:
- BASE_ADDR, 32'h3000_0000: decode base; a hit is wbs_adr_i[31:8]==BASE_ADDR[31:8].
- ADDR_W, 12: AXI-Lite address width; driven with wbs_adr_i[ADDR_W-1:0].
- DATA_W, 32: data width of all paths.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  asynchronous, active-low reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic control.
- wbs_sel_i  in  4  ignored; all accesses are full-word.
- wbs_adr_i  in  32  address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- awaddr/araddr  out  ADDR_W; awvalid, wvalid, arvalid, rready  out  1; wdata  out  32.
- awready, wready, arready, rvalid  in  1; rdata  in  32.
- ss_tdata  out  32; ss_tvalid, ss_tlast  out  1; ss_tready  in  1.
- sm_tdata  in  32; sm_tvalid, sm_tlast  in  1; sm_tready  out  1.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - wbs_ack_o=0, wbs_dat_o=0.
  - All valid/ready outputs 0; addresses and data 0.
  - len_shadow=0, x_cnt=0, state IDLE.
  - Reset mid-transaction drops every valid immediately; a pending Wishbone cycle is never acked.
- Address map (offset = wbs_adr_i[7:0]):
  - 0x00–0x7F: AXI-Lite. 0x00 = ap_ctrl, 0x10 = data_length, 0x40–0x7F = taps.
  - 0x80: X stream; writes only.
  - 0x84: Y stream; reads only.
  - Any other offset, and write-to-0x84 or read-of-0x80: ACK path, no side effect, read data 0.
- Non-hit addresses are never acked; another slave owns them.
- FSM states: IDLE, LITE_WR, LITE_RD, SS_PUSH, SM_POP, ACK.
- IDLE:
  - On cyc&stb&hit, latch address and data, then branch by offset and we.
  - A request accepted in IDLE is never re-evaluated; ACK returns to IDLE only after the ack edge.
- LITE_WR:
  - awvalid and wvalid rise together on entry.
  - Each drops independently in the cycle after its own ready is sampled high.
  - Go to ACK once both handshakes are done; order is arbitrary, simultaneous is allowed.
  - Snoop side effects:
    - Offset 0x10: len_shadow<=wdata.
    - Offset 0x00 with wdata[0]=1 (ap_start): x_cnt<=0.
- LITE_RD:
  - arvalid until arready is sampled.
  - Then rready=1 until rvalid is sampled; capture rdata into wbs_dat_o; go to ACK.
- SS_PUSH:
  - ss_tvalid=1 with ss_tdata=latched data.
  - ss_tlast = (len_shadow!=0 && x_cnt==len_shadow-1).
  - Outputs are held stable until ss_tready.
  - On handshake: x_cnt <= tlast ? 0 : x_cnt+1 (32-bit), then go to ACK.
- SM_POP:
  - sm_tready=1 until sm_tvalid; capture sm_tdata into wbs_dat_o; go to ACK.
  - sm_tlast is ignored.
- ACK: wbs_ack_o=1 for exactly one cycle, then IDLE.
- Minimum latency from stb sampled to ack high, with ready already high: 3 cycles (IDLE, op, ACK). The ACK-only path takes 2 cycles.
- Wait states are unbounded. Firmware must poll ap_ctrl before stream accesses; the bridge has no timeout.
- wbs_dat_o holds its last value outside ACK.

Decomposition:
- Package fir_bridge_pkg: offset constants (OFF_AP_CTRL, OFF_DLEN, OFF_TAP_LO/HI, OFF_X, OFF_Y) and the state enum.
- One sub-module, axil_master_if: owns the aw/w/ar/r valid/ready bookkeeping and reports done plus rdata to the main FSM.

Test Plan:
- Write 0x3000_0010=64 with awready delayed 2 cycles and wready immediate -> wvalid drops first, awvalid 2 cycles later; ack exactly once; len_shadow=64.
- Read 0x3000_0040 with arready=1 and rvalid after 3 cycles returning 0x1234 -> wbs_dat_o=0x0000_1234 on the ack cycle; rready high only after the ar handshake.
- data_length=3, ap_start, then write X three times -> ss_tlast only on the third push; x_cnt returns to 0; a fourth push has tlast=0.
- Write X with ss_tready low for 10 cycles -> ss_tvalid/ss_tdata stable, no ack until the handshake, ack 1 cycle after.
- Read 0x3000_0084 with sm_tvalid=1, sm_tdata=0xFFFF_FFF0 -> ack in 3 cycles, data 0xFFFF_FFF0; read of 0x3000_0080 -> ack in 2 cycles, data 0.
- Assert wb_rst_i low during LITE_WR -> awvalid/wvalid are 0 immediately; after release, state IDLE and no ack issued.
